// File: rtl/rvv_backend_vrf_pkg.sv
// Shared types and constants for the VRF write-port controller.
`ifndef VLEN
`define VLEN 128
`endif
`ifndef NUM_VRF
`define NUM_VRF 32
`endif

package rvv_backend_vrf_pkg;

  localparam int VRF_IDX_W = 5;
  localparam int VRF_VLEN  = `VLEN;
  localparam int VRF_VLENB = `VLEN / 8;
  localparam int VRF_NUM   = `NUM_VRF;

  typedef struct packed {
    logic [VRF_IDX_W-1:0] vd;
    logic [VRF_VLENB-1:0] strb;
    logic [VRF_VLEN-1:0]  data;
  } vrf_wr_req_t;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } vrf_clr_state_e;

endpackage

// File: rtl/rvv_backend_vrf_wr_merge.sv
// Combinational merge of the accepted request prefix into per-register
// bit enables and data. Younger (higher index) requests win overlapping bytes.
module rvv_backend_vrf_wr_merge
  import rvv_backend_vrf_pkg::*;
#(
  parameter int NUM_WP  = 2,
  parameter int VLEN    = `VLEN,
  parameter int VLENB   = VLEN / 8,
  parameter int NUM_VRF = `NUM_VRF
) (
  input  logic        [NUM_WP-1:0]             acc,
  input  vrf_wr_req_t [NUM_WP-1:0]             req,
  output logic        [NUM_VRF-1:0][VLEN-1:0]  wenb,
  output logic        [NUM_VRF-1:0][VLEN-1:0]  wdata
);

  // Walk ports oldest to youngest so a later byte write overrides an earlier one
  always_comb begin
    wenb  = '0;
    wdata = '0;
    for (int i = 0; i < NUM_WP; i++) begin
      if (acc[i]) begin
        for (int b = 0; b < VLENB; b++) begin
          if (req[i].strb[b]) begin
            wenb[req[i].vd][8*b +: 8]  = 8'hFF;
            wdata[req[i].vd][8*b +: 8] = req[i].data[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/rvv_backend_vrf_wr_ctrl.sv
// VRF write-port controller: in-order handshake, byte merge, registered
// write buses and a sequential clear FSM that zeroes one register per cycle.
module rvv_backend_vrf_wr_ctrl
  import rvv_backend_vrf_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_WP  = 2,
  parameter int VLEN    = `VLEN,
  parameter int VLENB   = VLEN / 8,
  parameter int NUM_VRF = `NUM_VRF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   wr_valid,
  input  logic [NUM_REQ-1:0][VRF_IDX_W-1:0]    wr_vd,
  input  logic [NUM_REQ-1:0][VLENB-1:0]        wr_strb,
  input  logic [NUM_REQ-1:0][VLEN-1:0]         wr_data,
  output logic [NUM_REQ-1:0]                   wr_ready,
  input  logic                                 clr_start,
  output logic                                 clr_busy,
  output logic                                 clr_done,
  output logic [NUM_VRF-1:0][VLEN-1:0]         vrf_wenb,
  output logic [NUM_VRF-1:0][VLEN-1:0]         vrf_wdata
);

  vrf_clr_state_e                  state;
  logic [VRF_IDX_W-1:0]            ptr;
  logic [NUM_WP-1:0]               acc;
  vrf_wr_req_t [NUM_WP-1:0]        req;
  logic [NUM_VRF-1:0][VLEN-1:0]    merge_wenb;
  logic [NUM_VRF-1:0][VLEN-1:0]    merge_wdata;

  // Ready is an in-order prefix: port i only if every older port is valid
  always_comb begin
    logic older_ok;
    wr_ready = '0;
    older_ok = (state == IDLE) && !clr_start;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i < NUM_WP) begin
        wr_ready[i] = older_ok;
      end
      older_ok = older_ok & wr_valid[i];
    end
  end

  // Pack the committable ports for the merge stage
  always_comb begin
    for (int i = 0; i < NUM_WP; i++) begin
      acc[i]      = wr_valid[i] & wr_ready[i];
      req[i].vd   = wr_vd[i];
      req[i].strb = wr_strb[i];
      req[i].data = wr_data[i];
    end
  end

  generate
    if (NUM_WP < NUM_REQ) begin : g_unused
      logic unused_ports;
      assign unused_ports = ^{wr_vd[NUM_REQ-1:NUM_WP], wr_strb[NUM_REQ-1:NUM_WP],
                              wr_data[NUM_REQ-1:NUM_WP]};
    end
  endgenerate

  rvv_backend_vrf_wr_merge #(
    .NUM_WP  (NUM_WP),
    .VLEN    (VLEN),
    .VLENB   (VLENB),
    .NUM_VRF (NUM_VRF)
  ) u_merge (
    .acc   (acc),
    .req   (req),
    .wenb  (merge_wenb),
    .wdata (merge_wdata)
  );

  // Clear FSM plus output registers; the clear sweep overrides normal writes
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      clr_busy  <= 1'b0;
      clr_done  <= 1'b0;
      vrf_wenb  <= '0;
      vrf_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          vrf_wenb  <= merge_wenb;
          vrf_wdata <= merge_wdata;
          clr_done  <= 1'b0;
          if (clr_start) begin
            state    <= CLEAR;
            ptr      <= '0;
            clr_busy <= 1'b1;
          end else begin
            clr_busy <= 1'b0;
          end
        end
        CLEAR: begin
          vrf_wenb      <= '0;
          vrf_wenb[ptr] <= '1;
          vrf_wdata     <= '0;
          clr_busy      <= 1'b1;
          if (ptr == VRF_IDX_W'(NUM_VRF - 1)) begin
            state    <= DONE;
            ptr      <= '0;
            clr_done <= 1'b1;
          end else begin
            ptr      <= ptr + VRF_IDX_W'(1);
            clr_done <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          clr_busy  <= 1'b0;
          clr_done  <= 1'b0;
          vrf_wenb  <= '0;
          vrf_wdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rvv_backend_vrf_wr_ctrl.sv
// Scoreboard bench for the VRF write-port controller with a cycle-level
// reference model driven by directed and randomized stimulus.
module tb_rvv_backend_vrf_wr_ctrl;
  import rvv_backend_vrf_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int NUM_WP  = 2;
  localparam int VLEN    = VRF_VLEN;
  localparam int VLENB   = VRF_VLENB;
  localparam int NUM_VRF = VRF_NUM;

  typedef struct {
    logic [NUM_VRF-1:0][VLEN-1:0] wenb;
    logic [NUM_VRF-1:0][VLEN-1:0] wdata;
    logic                         busy;
    logic                         done;
  } exp_t;

  logic                              clk;
  logic                              rst;
  logic [NUM_REQ-1:0]                wr_valid;
  logic [NUM_REQ-1:0][VRF_IDX_W-1:0] wr_vd;
  logic [NUM_REQ-1:0][VLENB-1:0]     wr_strb;
  logic [NUM_REQ-1:0][VLEN-1:0]      wr_data;
  logic [NUM_REQ-1:0]                wr_ready;
  logic                              clr_start;
  logic                              clr_busy;
  logic                              clr_done;
  logic [NUM_VRF-1:0][VLEN-1:0]      vrf_wenb;
  logic [NUM_VRF-1:0][VLEN-1:0]      vrf_wdata;

  // Stimulus staging variables consumed by applyStimulus
  logic                              s_rst;
  logic                              s_clr;
  logic [NUM_REQ-1:0]                s_valid;
  logic [NUM_REQ-1:0][VRF_IDX_W-1:0] s_vd;
  logic [NUM_REQ-1:0][VLENB-1:0]     s_strb;
  logic [NUM_REQ-1:0][VLEN-1:0]      s_data;

  exp_t               out_q[$];
  logic [NUM_REQ-1:0] ready_q[$];
  int                 phase;
  int                 n_cmp;
  int                 n_bad;

  rvv_backend_vrf_wr_ctrl #(
    .NUM_REQ (NUM_REQ),
    .NUM_WP  (NUM_WP),
    .VLEN    (VLEN),
    .VLENB   (VLENB),
    .NUM_VRF (NUM_VRF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_vd     (wr_vd),
    .wr_strb   (wr_strb),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .vrf_wenb  (vrf_wenb),
    .vrf_wdata (vrf_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs and push the model's expectations
  task automatic applyStimulus();
    exp_t               e;
    logic [NUM_REQ-1:0] er;
    logic               older_ok;
    @(negedge clk);
    rst       = s_rst;
    clr_start = s_clr;
    wr_valid  = s_valid;
    wr_vd     = s_vd;
    wr_strb   = s_strb;
    wr_data   = s_data;

    er = '0;
    if (phase < 0 && !s_clr) begin
      older_ok = 1'b1;
      for (int i = 0; i < NUM_WP; i++) begin
        er[i]    = older_ok;
        older_ok = older_ok & s_valid[i];
      end
    end
    ready_q.push_back(er);

    e.wenb  = '0;
    e.wdata = '0;
    e.busy  = 1'b0;
    e.done  = 1'b0;
    if (s_rst) begin
      phase = -1;
    end else if (phase < 0) begin
      if (s_clr) begin
        phase  = 0;
        e.busy = 1'b1;
      end else begin
        for (int r = 0; r < NUM_VRF; r++) begin
          for (int b = 0; b < VLENB; b++) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
              if (er[i] && s_valid[i] && int'(s_vd[i]) == r && s_strb[i][b]) begin
                e.wenb[r][8*b +: 8]  = 8'hFF;
                e.wdata[r][8*b +: 8] = s_data[i][8*b +: 8];
                break;
              end
            end
          end
        end
      end
    end else if (phase < NUM_VRF) begin
      e.wenb[phase] = '1;
      e.busy        = 1'b1;
      phase         = phase + 1;
      e.done        = (phase == NUM_VRF);
    end else begin
      phase = -1;
    end
    out_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [NUM_VRF-1:0][VLEN-1:0] act,
                             input logic [NUM_VRF-1:0][VLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      for (int r = 0; r < NUM_VRF; r++) begin
        if (act[r] !== exp[r]) begin
          $display("[TB] FAIL %s reg %0d at %0t: got %h expected %h", name, r, $time,
                   act[r], exp[r]);
          break;
        end
      end
    end
  endtask

  // Ready monitor: sample after the inputs have settled in the low phase
  initial begin
    logic [NUM_REQ-1:0] er;
    forever begin
      @(negedge clk);
      #2;
      if (ready_q.size() > 0) begin
        er = ready_q.pop_front();
        n_cmp++;
        if (wr_ready !== er) begin
          n_bad++;
          $display("[TB] FAIL wr_ready at %0t: got %b expected %b", $time, wr_ready, er);
        end
      end
    end
  end

  // Output monitor: registered buses and clear status just after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (out_q.size() > 0) begin
        e = out_q.pop_front();
        checkOutput("vrf_wenb", vrf_wenb, e.wenb);
        checkOutput("vrf_wdata", vrf_wdata, e.wdata);
        n_cmp++;
        if (clr_busy !== e.busy) begin
          n_bad++;
          $display("[TB] FAIL clr_busy at %0t: got %b expected %b", $time, clr_busy, e.busy);
        end
        n_cmp++;
        if (clr_done !== e.done) begin
          n_bad++;
          $display("[TB] FAIL clr_done at %0t: got %b expected %b", $time, clr_done, e.done);
        end
      end
    end
  end

  task automatic clearStim();
    s_rst   = 1'b0;
    s_clr   = 1'b0;
    s_valid = '0;
    s_vd    = '0;
    s_strb  = '0;
    s_data  = '0;
  endtask

  // Directed scenarios followed by a randomized run
  initial begin
    n_cmp = 0;
    n_bad = 0;
    phase = -1;
    rst = 1'b1; clr_start = 1'b0; wr_valid = '0;
    wr_vd = '0; wr_strb = '0; wr_data = '0;
    @(posedge clk);

    clearStim();
    s_rst = 1'b1;
    applyStimulus();
    applyStimulus();
    clearStim();
    applyStimulus();

    // Four valid requests, only two commit; then the rest shift down
    s_valid = 4'b1111;
    s_vd[0] = 5'd3; s_vd[1] = 5'd7; s_vd[2] = 5'd9; s_vd[3] = 5'd11;
    s_strb  = {NUM_REQ{ {VLENB{1'b1}} }};
    s_data[0] = {(VLEN/4){4'hA}};
    s_data[1] = {(VLEN/4){4'hB}};
    s_data[2] = {(VLEN/4){4'hC}};
    s_data[3] = {(VLEN/4){4'hD}};
    applyStimulus();
    s_valid = 4'b0011;
    s_vd[0] = 5'd9; s_vd[1] = 5'd11;
    s_data[0] = {(VLEN/4){4'hC}};
    s_data[1] = {(VLEN/4){4'hD}};
    applyStimulus();

    // Younger port valid while older is not: nothing commits
    clearStim();
    s_valid = 4'b0010;
    s_vd[1] = 5'd4;
    s_strb[1] = '1;
    s_data[1] = {(VLEN/4){4'h5}};
    applyStimulus();

    // Same-register merge with overlapping bytes
    clearStim();
    s_valid = 4'b0011;
    s_vd[0] = 5'd5; s_vd[1] = 5'd5;
    s_strb[0] = VLENB'(16'h000F);
    s_strb[1] = VLENB'(16'h0003);
    s_data[0] = {(VLEN/8){8'h11}};
    s_data[1] = {(VLEN/8){8'h22}};
    applyStimulus();

    // Zero-strobe request still handshakes
    clearStim();
    s_valid = 4'b0001;
    s_vd[0] = 5'd31;
    s_data[0] = '1;
    applyStimulus();

    // Clear beats a simultaneous request; held request lands after DONE
    clearStim();
    s_clr = 1'b1;
    s_valid = 4'b0001;
    s_vd[0] = 5'd12;
    s_strb[0] = '1;
    s_data[0] = {(VLEN/4){4'hE}};
    applyStimulus();
    s_clr = 1'b0;
    for (int c = 1; c <= NUM_VRF + 2; c++) begin
      s_clr = (c == 6);
      applyStimulus();
    end

    // Reset in the cycle register 10 shows up, then a fresh clear
    clearStim();
    s_clr = 1'b1;
    applyStimulus();
    s_clr = 1'b0;
    for (int c = 1; c <= 11; c++) applyStimulus();
    s_rst = 1'b1;
    applyStimulus();
    s_rst = 1'b0;
    applyStimulus();
    s_clr = 1'b1;
    applyStimulus();
    s_clr = 1'b0;
    for (int c = 0; c < NUM_VRF + 3; c++) applyStimulus();

    // Randomized traffic with collisions, empty strobes, clears and resets
    for (int n = 0; n < 400; n++) begin
      s_rst = ($urandom_range(99) == 0);
      s_clr = ($urandom_range(59) == 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        s_valid[i] = ($urandom_range(3) != 0);
        s_vd[i]    = VRF_IDX_W'($urandom_range(7));
        s_strb[i]  = ($urandom_range(7) == 0) ? '0 : VLENB'($urandom);
        s_data[i]  = {$urandom, $urandom, $urandom, $urandom};
      end
      applyStimulus();
    end

    clearStim();
    applyStimulus();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_q.size() != 0 || ready_q.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL drain: got %0d/%0d pending expected 0/0", out_q.size(),
               ready_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
